// File: rtl/branch_predictor_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_param_if
//  Description : Bundles the IF lookup and ID update signals of the branch
//                predictor.
//                master - pipeline side: drives the PCs and the resolution
//                         info, and receives the prediction.
//                slave  - predictor side.
//                Signals:
//                  IF_PC, IF_PC_4          fetch PC under lookup and its +4
//                  ID_PC, ID_Jump_PC       resolving PC and its target
//                  ID_branch, ID_taken     conditional branch / redirect flags
//                  ID_bht_idx              BHT index carried down from IF
//                  btb_flush               invalidate the whole BTB
//                  IF_bht_idx              index used by this lookup
//                  predict_taken, btb_hit  raw prediction terms
//                  predict_do_branch       combined redirect decision
//                  Predict_PC              next fetch PC
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_param_if #(
    parameter int BHT_IDX_W = 4
);
    logic [31:0]          IF_PC;
    logic [31:0]          IF_PC_4;
    logic [31:0]          ID_PC;
    logic [31:0]          ID_Jump_PC;
    logic                 ID_branch;
    logic                 ID_taken;
    logic [BHT_IDX_W-1:0] ID_bht_idx;
    logic                 btb_flush;
    logic [BHT_IDX_W-1:0] IF_bht_idx;
    logic                 predict_taken;
    logic                 btb_hit;
    logic                 predict_do_branch;
    logic [31:0]          Predict_PC;

    modport master (
        output IF_PC, IF_PC_4, ID_PC, ID_Jump_PC, ID_branch, ID_taken,
               ID_bht_idx, btb_flush,
        input  IF_bht_idx, predict_taken, btb_hit, predict_do_branch, Predict_PC
    );

    modport slave (
        input  IF_PC, IF_PC_4, ID_PC, ID_Jump_PC, ID_branch, ID_taken,
               ID_bht_idx, btb_flush,
        output IF_bht_idx, predict_taken, btb_hit, predict_do_branch, Predict_PC
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_param.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_param
//  Description : Branch predictor for the 5-stage RV32I core. A direct-mapped
//                BHT of CTR_W-bit saturating counters is combined with a
//                fully associative BTB (valid bits, invalid-first then
//                round-robin replacement, flush).
//                Lookup from IF is purely combinational and sees only the
//                state before the clock edge. ID updates land on the edge.
//  Ports       : clk  - core clock
//                rst  - synchronous active-high reset
//                bp   - branch_predictor_param_if.slave (lookup/update bus)
//  Options     : GSHARE_EN - when defined, the BHT index is XORed with a
//                BHT_IDX_W-bit global history register updated at ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_param #(
    parameter int BHT_IDX_W   = 4,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_W       = 2,
    parameter int CTR_INIT    = 0
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    branch_predictor_param_if.slave   bp
);
    localparam int               c_BHT_N    = 1 << BHT_IDX_W;
    localparam int               c_PTR_W    = $clog2(BTB_ENTRIES);
    localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'(CTR_INIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_W-1:0]       r_ctr_q   [c_BHT_N];
    logic [BTB_ENTRIES-1:0] r_valid_q;
    logic [31:0]            r_tag_q   [BTB_ENTRIES];
    logic [31:0]            r_tgt_q   [BTB_ENTRIES];
    logic [c_PTR_W-1:0]     r_rr_q;

    logic [CTR_W-1:0]       w_ctr_d   [c_BHT_N];
    logic [BTB_ENTRIES-1:0] w_valid_d;
    logic [31:0]            w_tag_d   [BTB_ENTRIES];
    logic [31:0]            w_tgt_d   [BTB_ENTRIES];
    logic [c_PTR_W-1:0]     w_rr_d;

    logic [BHT_IDX_W-1:0]   w_if_idx;
    logic                   w_hit;
    logic [31:0]            w_hit_tgt;
    logic [CTR_W-1:0]       w_cur_ctr;
    logic                   w_match;
    logic [c_PTR_W-1:0]     w_match_idx;
    logic                   w_free;
    logic [c_PTR_W-1:0]     w_free_idx;

    // ------------------------------------------------------------------
    // Global history and lookup index
    // ------------------------------------------------------------------
`ifdef GSHARE_EN
    logic [BHT_IDX_W-1:0] r_ghr_q;
    logic [BHT_IDX_W-1:0] w_ghr_d;

    // Shift in the resolved direction; truncation drops the oldest bit and
    // also covers the single-bit history case.
    always_comb begin
        w_ghr_d = r_ghr_q;
        if (bp.ID_branch) begin
            w_ghr_d = BHT_IDX_W'({r_ghr_q, bp.ID_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr_q <= '0;
        end else begin
            r_ghr_q <= w_ghr_d;
        end
    end

    assign w_if_idx = bp.IF_PC[BHT_IDX_W+1:2] ^ r_ghr_q;
`else
    assign w_if_idx = bp.IF_PC[BHT_IDX_W+1:2];
`endif

    // ------------------------------------------------------------------
    // Combinational lookup (pre-edge state only, no ID bypass)
    // ------------------------------------------------------------------
    // Ascending scan: should duplicate tags ever exist, the highest index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_tgt = '0;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            if (r_valid_q[i] && (r_tag_q[i] == bp.IF_PC)) begin
                w_hit     = 1'b1;
                w_hit_tgt = r_tgt_q[i];
            end
        end
    end

    assign bp.IF_bht_idx        = w_if_idx;
    assign bp.predict_taken     = r_ctr_q[w_if_idx][CTR_W-1];
    assign bp.btb_hit           = w_hit;
    assign bp.predict_do_branch = r_ctr_q[w_if_idx][CTR_W-1] & w_hit;
    assign bp.Predict_PC        = (r_ctr_q[w_if_idx][CTR_W-1] & w_hit) ? w_hit_tgt
                                                                       : bp.IF_PC_4;

    // ------------------------------------------------------------------
    // BTB searches for the ID update
    // ------------------------------------------------------------------
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            if (r_valid_q[i] && (r_tag_q[i] == bp.ID_PC)) begin
                w_match     = 1'b1;
                w_match_idx = c_PTR_W'(i);
            end
        end
    end

    // Descending scan so the lowest-index free slot is the one kept.
    always_comb begin
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid_q[i]) begin
                w_free     = 1'b1;
                w_free_idx = c_PTR_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for BHT and BTB
    // ------------------------------------------------------------------
    assign w_cur_ctr = r_ctr_q[bp.ID_bht_idx];

    always_comb begin
        w_ctr_d   = r_ctr_q;
        w_valid_d = r_valid_q;
        w_tag_d   = r_tag_q;
        w_tgt_d   = r_tgt_q;
        w_rr_d    = r_rr_q;

        // Only conditional branches train the counters; jal/jalr do not.
        if (bp.ID_branch) begin
            if (bp.ID_taken) begin
                if (w_cur_ctr != c_CTR_MAX) begin
                    w_ctr_d[bp.ID_bht_idx] = w_cur_ctr + CTR_W'(1);
                end
            end else begin
                if (w_cur_ctr != '0) begin
                    w_ctr_d[bp.ID_bht_idx] = w_cur_ctr - CTR_W'(1);
                end
            end
        end

        // Flush wins over a same-cycle allocation, which is simply dropped.
        if (bp.btb_flush) begin
            w_valid_d = '0;
            w_rr_d    = '0;
        end else if (bp.ID_taken) begin
            if (w_match) begin
                w_tgt_d[w_match_idx] = bp.ID_Jump_PC;
            end else if (w_free) begin
                w_valid_d[w_free_idx] = 1'b1;
                w_tag_d[w_free_idx]   = bp.ID_PC;
                w_tgt_d[w_free_idx]   = bp.ID_Jump_PC;
            end else begin
                // Power-of-two entry count: the pointer wraps naturally.
                w_tag_d[r_rr_q] = bp.ID_PC;
                w_tgt_d[r_rr_q] = bp.ID_Jump_PC;
                w_rr_d          = r_rr_q + c_PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr_q   <= '{default: c_CTR_INIT};
            r_valid_q <= '0;
            r_rr_q    <= '0;
        end else begin
            r_ctr_q   <= w_ctr_d;
            r_valid_q <= w_valid_d;
            r_rr_q    <= w_rr_d;
        end
    end

    // Tags and targets are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        r_tag_q <= w_tag_d;
        r_tgt_q <= w_tgt_d;
    end
endmodule
`default_nettype wire
